// File: rtl/golden_response_checker_pkg.sv
// Shared types and MISR constants for the golden response checker.
// No logic here; imported by the checker and its MISR.
// Not applicable: no flow control in a package.
package golden_response_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // x^16 + x^12 + x^5 + 1
    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

endpackage

// File: rtl/resp_chk_misr.sv
// 16-bit multiple-input signature register over accepted response pairs.
// Latency: sig reflects an absorbed word one cycle after shift_en.
// Backpressure: none; shifts only when the parent accepts a pair.
module resp_chk_misr
    import golden_response_checker_pkg::*;
#(
    parameter int DATA_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] data_in,
    output logic [15:0]       sig
);

    logic [15:0] feedback;
    logic [15:0] data_ext;

    assign feedback = sig[15] ? MISR_POLY : 16'h0000;
    assign data_ext = {{(16-DATA_W){1'b0}}, data_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= MISR_SEED;
        end else if (clear) begin
            sig <= MISR_SEED;
        end else if (shift_en) begin
            sig <= {sig[14:0], 1'b0} ^ feedback ^ data_ext;
        end
    end

endmodule

// File: rtl/golden_response_checker.sv
// Checks (pattern, observed bit) pairs of an exhaustive sweep against a golden table; optional MISR via RESP_CHK_MISR_EN.
// Latency: counters and flags reflect an accepted pair one cycle after the accept edge.
// Backpressure: obs_ready is high only while a sweep runs; pairs offered at other times are dropped.
module golden_response_checker
    import golden_response_checker_pkg::*;
#(
    parameter int N_IN  = 5,
    parameter int CNT_W = N_IN + 1
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             tbl_wr_en,
    input  logic [N_IN-1:0]  tbl_wr_addr,
    input  logic             tbl_wr_data,
    input  logic             start,
    input  logic             obs_valid,
    output logic             obs_ready,
    input  logic [N_IN-1:0]  obs_pattern,
    input  logic             obs_bit,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             seq_err,
    output logic             first_fail_valid,
    output logic [N_IN-1:0]  first_fail_pattern
`ifdef RESP_CHK_MISR_EN
    ,
    output logic [15:0]      sig
`endif
);

    localparam int DEPTH = 1 << N_IN;

    state_t          state_q;
    state_t          state_d;
    logic [N_IN-1:0] exp_idx;
    logic            tbl [DEPTH];
    logic            accept;
    logic            last_accept;
    logic            enter_run;
    logic            mis;

    assign obs_ready   = (state_q == RUN);
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign pass        = done && (mismatch_cnt == '0) && !seq_err;
    assign accept      = obs_valid && obs_ready;
    assign last_accept = accept && (&exp_idx);
    assign enter_run   = start && (state_q != RUN);
    assign mis         = obs_bit ^ tbl[obs_pattern];

    // Golden table is deliberately not reset so it survives a mid-sweep reset.
    always_ff @(posedge CK) begin
        if (tbl_wr_en && (state_q != RUN)) begin
            tbl[tbl_wr_addr] <= tbl_wr_data;
        end
    end

    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)       state_d = RUN;
            RUN:     if (last_accept) state_d = DONE;
            DONE:    if (start)       state_d = RUN;
            default:                  state_d = IDLE;
        endcase
    end

    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            exp_idx            <= '0;
            mismatch_cnt       <= '0;
            seq_err            <= 1'b0;
            first_fail_valid   <= 1'b0;
            first_fail_pattern <= '0;
        end else if (enter_run) begin
            exp_idx            <= '0;
            mismatch_cnt       <= '0;
            seq_err            <= 1'b0;
            first_fail_valid   <= 1'b0;
            first_fail_pattern <= '0;
        end else if (accept) begin
            exp_idx <= exp_idx + N_IN'(1);
            if (mis && (mismatch_cnt != '1)) begin
                mismatch_cnt <= mismatch_cnt + CNT_W'(1);
            end
            if (mis && !first_fail_valid) begin
                first_fail_valid   <= 1'b1;
                first_fail_pattern <= obs_pattern;
            end
            // Out-of-order pattern is flagged but still compared at its own address.
            if (obs_pattern != exp_idx) begin
                seq_err <= 1'b1;
            end
        end
    end

`ifdef RESP_CHK_MISR_EN
    resp_chk_misr #(
        .DATA_W (N_IN + 1)
    ) u_misr (
        .clk      (CK),
        .rst      (reset),
        .clear    (enter_run),
        .shift_en (accept),
        .data_in  ({obs_pattern, obs_bit}),
        .sig      (sig)
    );
`endif

endmodule

// File: tb/tb_golden_response_checker.sv
// Self-checking bench for golden_response_checker: directed sweeps against a behavioural sweep model.
module tb_golden_response_checker;

    localparam int N_IN  = 5;
    localparam int CNT_W = 6;
    localparam int DEPTH = 32;

    logic             CK = 1'b0;
    logic             reset = 1'b0;
    logic             tbl_wr_en = 1'b0;
    logic [N_IN-1:0]  tbl_wr_addr = '0;
    logic             tbl_wr_data = 1'b0;
    logic             start = 1'b0;
    logic             obs_valid = 1'b0;
    logic             obs_ready;
    logic [N_IN-1:0]  obs_pattern = '0;
    logic             obs_bit = 1'b0;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] mismatch_cnt;
    logic             seq_err;
    logic             first_fail_valid;
    logic [N_IN-1:0]  first_fail_pattern;
`ifdef RESP_CHK_MISR_EN
    logic [15:0]      sig;
    logic [15:0]      sig_first;
`endif

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    golden_response_checker dut (
        .CK                 (CK),
        .reset              (reset),
        .tbl_wr_en          (tbl_wr_en),
        .tbl_wr_addr        (tbl_wr_addr),
        .tbl_wr_data        (tbl_wr_data),
        .start              (start),
        .obs_valid          (obs_valid),
        .obs_ready          (obs_ready),
        .obs_pattern        (obs_pattern),
        .obs_bit            (obs_bit),
        .busy               (busy),
        .done               (done),
        .pass               (pass),
        .mismatch_cnt       (mismatch_cnt),
        .seq_err            (seq_err),
        .first_fail_valid   (first_fail_valid),
        .first_fail_pattern (first_fail_pattern)
`ifdef RESP_CHK_MISR_EN
        ,
        .sig                (sig)
`endif
    );

    always #5 CK = ~CK;

    function automatic logic par(input logic [4:0] p);
        return ^p;
    endfunction

    function automatic logic [15:0] misr_next(input logic [15:0] s, input logic [5:0] d);
        logic [16:0] t;
        t = {s, 1'b0};
        if (t[16]) t[15:0] = t[15:0] ^ 16'h1021;
        return t[15:0] ^ {10'b0, d};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Sweep-level model: tracks the running sweep by counting accepted pairs.
    logic        m_tbl [DEPTH];
    bit          m_run, m_done, m_seq, m_ffv;
    int          m_cnt, m_acc;
    logic [4:0]  m_ffp;
    logic [15:0] m_sig;

    always @(posedge CK or posedge reset) begin
        if (reset) begin
            m_run = 0; m_done = 0; m_seq = 0; m_ffv = 0;
            m_cnt = 0; m_acc = 0; m_ffp = '0; m_sig = 16'hFFFF;
        end else begin
            if (tbl_wr_en && !m_run) m_tbl[tbl_wr_addr] = tbl_wr_data;
            if (m_run && obs_valid) begin
                if (obs_bit !== m_tbl[obs_pattern]) begin
                    if (m_cnt < 63) m_cnt++;
                    if (!m_ffv) begin
                        m_ffv = 1; m_ffp = obs_pattern;
                    end
                end
                if (int'(obs_pattern) != (m_acc % DEPTH)) m_seq = 1;
                m_sig = misr_next(m_sig, {obs_pattern, obs_bit});
                m_acc++;
                if (m_acc == DEPTH) begin
                    m_run = 0; m_done = 1;
                end
            end else if (start && !m_run) begin
                m_run = 1; m_done = 0; m_seq = 0; m_ffv = 0;
                m_cnt = 0; m_acc = 0; m_ffp = '0; m_sig = 16'hFFFF;
            end
        end
    end

    always @(negedge CK) begin
        if (cmp_en && !reset) begin
            chk("cycle_outputs",
                {15'b0, obs_ready, busy, done, pass, mismatch_cnt, seq_err, first_fail_valid, first_fail_pattern},
                {15'b0, m_run, m_run, m_done, (m_done && m_cnt == 0 && !m_seq), 6'(m_cnt), m_seq, m_ffv, m_ffp});
`ifdef RESP_CHK_MISR_EN
            chk("cycle_sig", {16'b0, sig}, {16'b0, m_sig});
`endif
        end
    end

    task automatic tick;
        @(posedge CK);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_obs_ready"}, obs_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_mismatch_cnt"}, mismatch_cnt, 0);
        chk({tag, "_seq_err"}, seq_err, 0);
        chk({tag, "_ffv"}, first_fail_valid, 0);
        chk({tag, "_ffp"}, first_fail_pattern, 0);
`ifdef RESP_CHK_MISR_EN
        chk({tag, "_sig"}, sig, 16'hFFFF);
`endif
    endtask

    // Last table write shares its cycle with start.
    task automatic load_parity_and_start;
        for (int a = 0; a < DEPTH; a++) begin
            tbl_wr_en = 1; tbl_wr_addr = 5'(a); tbl_wr_data = par(5'(a));
            start = (a == DEPTH - 1);
            tick;
        end
        tbl_wr_en = 0; start = 0;
    endtask

    // mode 0 clean, 1 two flipped bits, 2 out-of-order pattern, 3 every bit flipped
    task automatic sweep(input int mode, input bit do_start, input bit stall);
        logic [4:0] p;
        logic       b;
        int         n;
        if (do_start) begin
            start = 1; tick; start = 0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (stall) repeat ($urandom_range(0, 2)) tick;
            p = (mode == 2 && i == 2) ? 5'd3 : 5'(i);
            b = par(p);
            if (mode == 1 && (p == 5'b10110 || p == 5'b11011)) b = ~b;
            if (mode == 3) b = ~b;
            obs_valid = 1; obs_pattern = p; obs_bit = b;
            if (stall && i == 10) start = 1;
            if (stall && i == 15) begin
                tbl_wr_en = 1; tbl_wr_addr = 5'd20; tbl_wr_data = ~par(5'd20);
            end
            tick;
            obs_valid = 0; start = 0; tbl_wr_en = 0;
        end
        n = 0;
        while (!done && n < 8) begin
            tick; n++;
        end
        chk("sweep_done", done, 1);
    endtask

    initial begin
        #2 reset = 1;
        #1 check_reset_values("reset");
        tick; tick;
        reset = 0;
        cmp_en = 1;

        // 1) parity table, clean sweep; write+start share a cycle
        load_parity_and_start;
        sweep(0, 0, 0);
        chk("t1_pass", pass, 1);
        chk("t1_cnt", mismatch_cnt, 0);
        chk("t1_ffv", first_fail_valid, 0);

        // 2) two flipped responses
        sweep(1, 1, 0);
        chk("t2_cnt", mismatch_cnt, 2);
        chk("t2_ffp", first_fail_pattern, 5'b10110);
        chk("t2_ffv", first_fail_valid, 1);
        chk("t2_pass", pass, 0);

        // start in DONE clears results
        start = 1; tick; start = 0;
        chk("restart_cnt", mismatch_cnt, 0);
        chk("restart_ffv", first_fail_valid, 0);
        chk("restart_busy", busy, 1);
        chk("restart_done", done, 0);

        // 3) pattern 3 where index 2 expected
        sweep(2, 0, 0);
        chk("t3_seq_err", seq_err, 1);
        chk("t3_cnt", mismatch_cnt, 0);
        chk("t3_pass", pass, 0);

        // 4) reset after 12 accepts, table retained
        start = 1; tick; start = 0;
        for (int i = 0; i < 12; i++) begin
            obs_valid = 1; obs_pattern = 5'(i); obs_bit = ~par(5'(i));
            tick;
        end
        obs_valid = 0;
        chk("t4_cnt_before_reset", mismatch_cnt, 12);
        #2 reset = 1;
        #1 check_reset_values("midreset");
        tick;
        reset = 0;
        sweep(0, 1, 0);
        chk("t4_pass", pass, 1);

        // 5) stalls, start and table write mid-RUN
        sweep(0, 1, 1);
        chk("t5_pass", pass, 1);
        chk("t5_cnt", mismatch_cnt, 0);
        chk("t5_seq_err", seq_err, 0);

        // 6) every response inverted
        sweep(3, 1, 0);
        chk("t6_cnt", mismatch_cnt, 32);
        chk("t6_ffp", first_fail_pattern, 0);
        chk("t6_pass", pass, 0);
`ifdef RESP_CHK_MISR_EN
        sig_first = sig;
        sweep(3, 1, 0);
        chk("t6_sig_repeat", sig, sig_first);
        chk("t6_sig_model", sig, m_sig);
`endif

        cmp_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
